// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts decoded instructions, reads the register file with
// writeback bypass, and blocks RAW/WAW hazards against a per-register in-flight scoreboard.
module operand_fetch #(
  parameter int PAYLOAD_WIDTH = 64
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset_n,
  input  logic                     i_Valid,
  output logic                     o_Ready,
  input  logic [4:0]               i_Rs1,
  input  logic [4:0]               i_Rs2,
  input  logic                     i_Uses1,
  input  logic                     i_Uses2,
  input  logic [4:0]               i_Rd,
  input  logic                     i_RdWrite,
  input  logic [PAYLOAD_WIDTH-1:0] i_Payload,
  output logic [4:0]               o_RegSource1,
  output logic [4:0]               o_RegSource2,
  input  logic [31:0]              i_RegData1,
  input  logic [31:0]              i_RegData2,
  input  logic                     i_WbRetire,
  input  logic                     i_WbEnable,
  input  logic [4:0]               i_WbDest,
  input  logic [31:0]              i_WbData,
  input  logic                     i_Flush,
  output logic                     o_Valid,
  input  logic                     i_Ready,
  output logic [31:0]              o_Operand1,
  output logic [31:0]              o_Operand2,
  output logic [4:0]               o_Rd,
  output logic                     o_RdWrite,
  output logic [PAYLOAD_WIDTH-1:0] o_Payload
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Upstream i_Valid must not depend on o_Ready; o_Ready may look at the offered fields.
  // Downstream, the slot stays stable while o_Valid is high and i_Ready is low.

  logic [31:0] scoreboard;
  logic [31:0] clearMask;
  logic [31:0] slotMask;
  logic [31:0] setMask;
  logic [31:0] busyVec;
  logic        retireClr;
  logic        hazard;
  logic        fire;
  logic        accept;
  logic        bypass1;
  logic        bypass2;
  logic [31:0] captured1;
  logic [31:0] captured2;

  assign o_RegSource1 = i_Rs1;
  assign o_RegSource2 = i_Rs2;

  always_comb begin
    retireClr = i_WbRetire && (i_WbDest != 5'd0);
    clearMask = retireClr ? (32'd1 << i_WbDest) : 32'd0;
    slotMask  = (o_Valid && o_RdWrite) ? (32'd1 << o_Rd) : 32'd0;
    // The held slot counts as in flight; a register retiring this cycle is already free.
    busyVec   = ((scoreboard & ~clearMask) | slotMask) & ~32'd1;

    hazard  = (i_Uses1 && busyVec[i_Rs1]) ||
              (i_Uses2 && busyVec[i_Rs2]) ||
              (i_RdWrite && busyVec[i_Rd]);
    o_Ready = (!o_Valid || i_Ready) && !hazard && !i_Flush;
    fire    = o_Valid && i_Ready && !i_Flush;
    accept  = i_Valid && o_Ready;

    setMask = (fire && o_RdWrite && (o_Rd != 5'd0)) ? (32'd1 << o_Rd) : 32'd0;

    bypass1   = i_WbRetire && i_WbEnable && (i_WbDest == i_Rs1) && (i_Rs1 != 5'd0);
    bypass2   = i_WbRetire && i_WbEnable && (i_WbDest == i_Rs2) && (i_Rs2 != 5'd0);
    captured1 = bypass1 ? i_WbData : i_RegData1;
    captured2 = bypass2 ? i_WbData : i_RegData2;
  end

  // Set wins over clear when both target the same bit.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      scoreboard <= 32'd0;
    end else begin
      scoreboard <= (scoreboard & ~clearMask) | setMask;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Valid    <= 1'b0;
      o_Operand1 <= 32'd0;
      o_Operand2 <= 32'd0;
      o_Rd       <= 5'd0;
      o_RdWrite  <= 1'b0;
      o_Payload  <= '0;
    end else if (i_Flush) begin
      o_Valid <= 1'b0;
    end else if (accept) begin
      o_Valid    <= 1'b1;
      o_Operand1 <= captured1;
      o_Operand2 <= captured2;
      o_Rd       <= i_Rd;
      o_RdWrite  <= i_RdWrite;
      o_Payload  <= i_Payload;
    end else if (fire) begin
      o_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand-written hazard/flush/reset
// sequences, then random traffic checked against a queue-based pipeline model.
module tb_operand_fetch;
  localparam int PW = 64;

  logic          i_Clock;
  logic          i_Reset_n;
  logic          i_Valid;
  logic          o_Ready;
  logic [4:0]    i_Rs1, i_Rs2, i_Rd;
  logic          i_Uses1, i_Uses2, i_RdWrite;
  logic [PW-1:0] i_Payload;
  logic [4:0]    o_RegSource1, o_RegSource2;
  logic [31:0]   i_RegData1, i_RegData2;
  logic          i_WbRetire, i_WbEnable;
  logic [4:0]    i_WbDest;
  logic [31:0]   i_WbData;
  logic          i_Flush;
  logic          o_Valid;
  logic          i_Ready;
  logic [31:0]   o_Operand1, o_Operand2;
  logic [4:0]    o_Rd;
  logic          o_RdWrite;
  logic [PW-1:0] o_Payload;

  operand_fetch #(.PAYLOAD_WIDTH(PW)) dut (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_Rs1(i_Rs1), .i_Rs2(i_Rs2), .i_Uses1(i_Uses1), .i_Uses2(i_Uses2),
    .i_Rd(i_Rd), .i_RdWrite(i_RdWrite), .i_Payload(i_Payload),
    .o_RegSource1(o_RegSource1), .o_RegSource2(o_RegSource2),
    .i_RegData1(i_RegData1), .i_RegData2(i_RegData2),
    .i_WbRetire(i_WbRetire), .i_WbEnable(i_WbEnable), .i_WbDest(i_WbDest), .i_WbData(i_WbData),
    .i_Flush(i_Flush), .o_Valid(o_Valid), .i_Ready(i_Ready),
    .o_Operand1(o_Operand1), .o_Operand2(o_Operand2), .o_Rd(o_Rd), .o_RdWrite(o_RdWrite),
    .o_Payload(o_Payload)
  );

  // Clock / reset
  initial begin
    i_Clock = 1'b0;
    forever #5 i_Clock = ~i_Clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Register file model: x0 reads zero, written one step after the edge it was committed on
  logic [31:0] regs [32];
  assign i_RegData1 = (o_RegSource1 == 5'd0) ? 32'd0 : regs[o_RegSource1];
  assign i_RegData2 = (o_RegSource2 == 5'd0) ? 32'd0 : regs[o_RegSource2];

  int compared;
  int mismatched;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    i_Valid = 0; i_Rs1 = 0; i_Rs2 = 0; i_Uses1 = 0; i_Uses2 = 0;
    i_Rd = 0; i_RdWrite = 0; i_Payload = '0;
    i_WbRetire = 0; i_WbEnable = 0; i_WbDest = 0; i_WbData = 0; i_Flush = 0;
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic rdw);
    i_Valid = 1; i_Rs1 = rs1; i_Rs2 = rs2; i_Uses1 = u1; i_Uses2 = u2;
    i_Rd = rd; i_RdWrite = rdw; i_Payload = {32'hCAFE_0000, 27'd0, rd};
  endtask

  task automatic retire(input logic [4:0] dest, input logic en, input logic [31:0] data);
    i_WbRetire = 1; i_WbDest = dest; i_WbEnable = en; i_WbData = data;
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
    if (i_WbRetire && i_WbEnable && i_WbDest != 5'd0) regs[i_WbDest] = i_WbData;
  endtask

  // Vector table
  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic        rdw;
    logic        rdy;
    logic        expReady;
    logic        expValid;
    logic [31:0] expOp1, expOp2;
  } vec_t;
  vec_t vecs [8];

  // Reference model for random traffic
  typedef struct {
    logic [4:0] rd;
    logic       rdw;
    logic       killed;
  } inst_t;
  inst_t execQ [$];

  logic          mValid;
  logic [31:0]   mOp1, mOp2;
  logic [4:0]    mRd;
  logic          mRdw;
  logic [PW-1:0] mPay;

  function automatic logic model_busy(input logic [4:0] r, input logic skipHead);
    if (r == 5'd0) return 1'b0;
    if (mValid && mRdw && mRd == r) return 1'b1;
    for (int i = (skipHead ? 1 : 0); i < execQ.size(); i++)
      if (execQ[i].rdw && execQ[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = 32'd0;
    foreach (execQ[i])
      if (execQ[i].rdw && execQ[i].rd != 5'd0) m[execQ[i].rd] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_operand(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (i_WbRetire && i_WbEnable && i_WbDest == rs) return i_WbData;
    return regs[rs];
  endfunction

  initial begin
    logic          offered, expReady, expFire, expAccept, retiring;
    logic [4:0]    oRs1, oRs2, oRd;
    logic          oU1, oU2, oRdw;
    logic [PW-1:0] oPay;
    logic [31:0]   nOp1, nOp2;
    inst_t         slotInst;

    compared = 0;
    mismatched = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
    regs[0] = 32'd0;
    regs[3] = 32'h11;
    regs[4] = 32'h22;

    vecs[0] = '{1'b1, 5'd3,  5'd4,  1'b1, 1'b1, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1, 32'h11,   32'h22};
    vecs[1] = '{1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h0,    32'h0};
    vecs[2] = '{1'b1, 5'd10, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0};
    vecs[3] = '{1'b1, 5'd11, 5'd12, 1'b0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100B, 32'h100C};
    vecs[4] = '{1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100B, 32'h100C};
    vecs[5] = '{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100B, 32'h100C};
    vecs[6] = '{1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h0,    32'h0};
    vecs[7] = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    32'h0};

    // Reset
    idle();
    i_Ready = 1;
    i_Reset_n = 0;
    @(posedge i_Clock);
    @(posedge i_Clock);
    #1;
    i_Reset_n = 1;
    check("reset_valid", o_Valid, 0);
    check("reset_op1", o_Operand1, 0);
    check("reset_op2", o_Operand2, 0);
    check("reset_rd", {o_RdWrite, o_Rd}, 0);
    check("reset_payload", o_Payload, 0);
    check("reset_scoreboard", dut.scoreboard, 0);

    // Table-driven steps
    for (int i = 0; i < 8; i++) begin
      idle();
      if (vecs[i].valid) offer(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd, vecs[i].rdw);
      i_Ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_ready", i), o_Ready, vecs[i].expReady);
      check($sformatf("vec%0d_srcaddr", i), {o_RegSource1, o_RegSource2}, {vecs[i].rs1, vecs[i].rs2});
      tick();
      check($sformatf("vec%0d_valid", i), o_Valid, vecs[i].expValid);
      check($sformatf("vec%0d_op1", i), o_Operand1, vecs[i].expOp1);
      check($sformatf("vec%0d_op2", i), o_Operand2, vecs[i].expOp2);
    end
    check("vec_scoreboard", dut.scoreboard, 32'h0000_2400);
    idle(); retire(5'd10, 1'b1, 32'hAAAA); tick();
    idle(); retire(5'd13, 1'b0, 32'h0); tick();
    idle();
    check("vec_scoreboard_drained", dut.scoreboard, 0);

    // RAW stall resolved through the writeback bypass
    idle(); offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1); #1;
    check("raw_a_ready", o_Ready, 1);
    tick();
    idle(); offer(5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b0); #1;
    check("raw_slot_stall", o_Ready, 0);
    tick();
    check("raw_sb_stall", o_Ready, 0);
    tick();
    check("raw_sb_stall2", o_Ready, 0);
    retire(5'd5, 1'b1, 32'hDEAD); #1;
    check("raw_bypass_ready", o_Ready, 1);
    tick();
    check("raw_b_valid", o_Valid, 1);
    check("raw_bypass_op1", o_Operand1, 32'hDEAD);
    check("raw_b_rd", o_Rd, 5'd6);
    idle(); tick();
    check("raw_scoreboard", dut.scoreboard, 0);

    // Producer held by backpressure, consumer stalls before and after it fires
    idle(); i_Ready = 0; offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1); tick();
    idle(); offer(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0); #1;
    check("hold_ready", o_Ready, 0);
    tick();
    check("hold_valid", o_Valid, 1);
    check("hold_rd", o_Rd, 5'd7);
    i_Ready = 1; #1;
    check("hold_slot_hazard", o_Ready, 0);
    tick();
    check("hold_fired", o_Valid, 0);
    check("hold_post_fire_stall", o_Ready, 0);
    retire(5'd7, 1'b1, 32'h77); #1;
    check("hold_release", o_Ready, 1);
    tick();
    check("hold_b_valid", o_Valid, 1);
    check("hold_bypass_op2", o_Operand2, 32'h77);
    idle(); tick();

    // WAW: second writer of x9 waits until the first retires, even without a write
    idle(); offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1); tick();
    idle(); tick();
    offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1); #1;
    check("waw_stall", o_Ready, 0);
    tick();
    check("waw_stall2", o_Ready, 0);
    retire(5'd9, 1'b0, 32'h0); #1;
    check("waw_clear", o_Ready, 1);
    tick();
    check("waw_b_valid", o_Valid, 1);
    check("waw_b_rd", o_Rd, 5'd9);
    idle(); tick();
    check("waw_b_scoreboard", dut.scoreboard, 32'h200);
    retire(5'd9, 1'b0, 32'h0); tick();
    idle();
    check("waw_drained", dut.scoreboard, 0);

    // Flush drops both the held and the offered instruction
    idle(); offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1); tick();
    idle(); offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1); i_Flush = 1; #1;
    check("flush_ready", o_Ready, 0);
    tick();
    check("flush_valid", o_Valid, 0);
    check("flush_scoreboard", dut.scoreboard, 0);
    idle(); tick();
    check("flush_no_accept", o_Valid, 0);

    // Asynchronous reset in the middle of a stall
    idle(); offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1); tick();
    idle(); tick();
    offer(5'd0, 5'd0, 1'b0, 1'b0, 5'd13, 1'b1); tick();
    i_Ready = 0;
    idle(); offer(5'd12, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1); #1;
    check("rst_stall", o_Ready, 0);
    check("rst_pre_valid", o_Valid, 1);
    #1;
    i_Reset_n = 0;
    #1;
    check("rst_valid", o_Valid, 0);
    check("rst_scoreboard", dut.scoreboard, 0);
    check("rst_rd", o_Rd, 0);
    check("rst_payload", o_Payload, 0);
    idle();
    tick();
    tick();
    i_Reset_n = 1;
    i_Ready = 1;

    // Random traffic against the model
    mValid = 0; mOp1 = 0; mOp2 = 0; mRd = 0; mRdw = 0; mPay = '0;
    offered = 0;
    oRs1 = 0; oRs2 = 0; oU1 = 0; oU2 = 0; oRd = 0; oRdw = 0; oPay = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      if (!offered && $urandom_range(0, 1) == 1) begin
        offered = 1;
        oRs1 = 5'($urandom_range(0, 7)); oRs2 = 5'($urandom_range(0, 7));
        oU1 = 1'($urandom_range(0, 1));  oU2 = 1'($urandom_range(0, 1));
        oRd = 5'($urandom_range(0, 7));  oRdw = 1'($urandom_range(0, 1));
        oPay = {$urandom, $urandom};
      end
      if (offered) begin
        i_Valid = 1; i_Rs1 = oRs1; i_Rs2 = oRs2; i_Uses1 = oU1; i_Uses2 = oU2;
        i_Rd = oRd; i_RdWrite = oRdw; i_Payload = oPay;
      end
      i_Ready = ($urandom_range(0, 3) != 0);
      i_Flush = ($urandom_range(0, 24) == 0);
      retiring = 0;
      if (execQ.size() > 0 && $urandom_range(0, 2) != 0) begin
        retiring = 1;
        i_WbRetire = 1;
        i_WbDest = execQ[0].rdw ? execQ[0].rd : 5'd0;
        i_WbEnable = execQ[0].rdw && !execQ[0].killed;
        i_WbData = $urandom;
      end
      #1;

      expReady = (!mValid || i_Ready) && !i_Flush &&
                 !(i_Uses1 && model_busy(i_Rs1, retiring)) &&
                 !(i_Uses2 && model_busy(i_Rs2, retiring)) &&
                 !(i_RdWrite && model_busy(i_Rd, retiring));
      check("rnd_ready", o_Ready, expReady);
      if (i_WbRetire && i_WbDest != 5'd0)
        check("rnd_retire_of_idle", dut.scoreboard[i_WbDest], 1);

      expAccept = i_Valid && expReady;
      expFire = mValid && i_Ready && !i_Flush;
      nOp1 = model_operand(i_Rs1);
      nOp2 = model_operand(i_Rs2);

      if (retiring) void'(execQ.pop_front());
      if (i_Flush) foreach (execQ[i]) execQ[i].killed = 1'b1;
      if (expFire) begin
        slotInst.rd = mRd; slotInst.rdw = mRdw; slotInst.killed = 1'b0;
        execQ.push_back(slotInst);
      end
      if (i_Flush) begin
        mValid = 0;
        offered = 0;
      end else if (expAccept) begin
        mValid = 1; mOp1 = nOp1; mOp2 = nOp2; mRd = i_Rd; mRdw = i_RdWrite; mPay = i_Payload;
        offered = 0;
      end else if (expFire) begin
        mValid = 0;
      end

      tick();
      check("rnd_valid", o_Valid, mValid);
      if (mValid) begin
        check("rnd_op1", o_Operand1, mOp1);
        check("rnd_op2", o_Operand2, mOp2);
        check("rnd_rd", {o_RdWrite, o_Rd}, {mRdw, mRd});
        check("rnd_payload", o_Payload, mPay);
      end
      check("rnd_scoreboard", dut.scoreboard, model_mask());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
